// File: rtl/tx_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tx_pkg
// Description : Shared defaults and helper functions for the TX interpolator.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_pkg;

    localparam int c_DEF_STAGES    = 3;
    localparam int c_DEF_INTERP    = 8;
    localparam int c_DEF_IN_WIDTH  = 16;
    localparam int c_DEF_ACC_WIDTH = 25;
    localparam int c_DEF_OUT_SHIFT = 4;
    localparam int c_DEF_OUT_WIDTH = 18;

    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          result;
        v      = (value > 0) ? value - 1 : 0;
        result = 0;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Clamp a wide signed value into the range of a 'width'-bit signed word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                               input int unsigned       width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_cic_interp.sv
`default_nettype none
// ============================================================================
// Module      : tx_cic_interp
// Description : One-channel CIC interpolator: low-rate combs, zero-stuff,
//               full-rate integrators, arithmetic shift and output saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_cic_interp
    import tx_pkg::*;
#(
    parameter int STAGES    = c_DEF_STAGES,
    parameter int IN_WIDTH  = c_DEF_IN_WIDTH,
    parameter int ACC_WIDTH = c_DEF_ACC_WIDTH,
    parameter int OUT_SHIFT = c_DEF_OUT_SHIFT,
    parameter int OUT_WIDTH = c_DEF_OUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_tick,
    input  logic signed [IN_WIDTH-1:0]  i_sample,
    output logic signed [OUT_WIDTH-1:0] o_sample
);

    logic signed [ACC_WIDTH-1:0] w_comb_x [STAGES+1];
    logic signed [ACC_WIDTH-1:0] r_comb_prev [STAGES];
    logic signed [ACC_WIDTH-1:0] r_comb_out;
    logic                        r_stuff;
    logic signed [ACC_WIDTH-1:0] r_integ [STAGES];
    logic signed [ACC_WIDTH-1:0] w_integ_shr;
    logic signed [63:0]          w_wide;
    logic signed [63:0]          w_sat;
    logic signed [OUT_WIDTH-1:0] r_out;

    always_comb begin
        w_comb_x[0] = {{(ACC_WIDTH-IN_WIDTH){i_sample[IN_WIDTH-1]}}, i_sample};
        for (int k = 0; k < STAGES; k++) begin
            w_comb_x[k+1] = w_comb_x[k] - r_comb_prev[k];
        end
    end

    assign w_integ_shr = r_integ[STAGES-1] >>> OUT_SHIFT;
    assign w_wide      = {{(64-ACC_WIDTH){w_integ_shr[ACC_WIDTH-1]}}, w_integ_shr};
    assign w_sat       = sat(w_wide, OUT_WIDTH);

    // Integrators wrap freely; only the final output is saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_comb_prev[k] <= '0;
                r_integ[k]     <= '0;
            end
            r_comb_out <= '0;
            r_stuff    <= 1'b0;
            r_out      <= '0;
        end else begin
            if (i_tick) begin
                for (int k = 0; k < STAGES; k++) begin
                    r_comb_prev[k] <= w_comb_x[k];
                end
                r_comb_out <= w_comb_x[STAGES];
            end
            r_stuff    <= i_tick;
            r_integ[0] <= r_integ[0] + (r_stuff ? r_comb_out : {ACC_WIDTH{1'b0}});
            for (int k = 1; k < STAGES; k++) begin
                r_integ[k] <= r_integ[k] + r_integ[k-1];
            end
            r_out <= OUT_WIDTH'(w_sat);
        end
    end

    assign o_sample = r_out;

endmodule
`default_nettype wire

// File: rtl/tx_interpolator.sv
`default_nettype none
// ============================================================================
// Module      : tx_interpolator
// Description : TX I/Q interpolator: 2-deep input buffer with valid/ready,
//               phase counter and dual CIC, one output sample per clock.
//               Optional macro TX_UNDERRUN_CNT_EN adds underrun_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_interpolator
    import tx_pkg::*;
#(
    parameter int STAGES    = c_DEF_STAGES,
    parameter int INTERP    = c_DEF_INTERP,
    parameter int IN_WIDTH  = c_DEF_IN_WIDTH,
    parameter int ACC_WIDTH = c_DEF_ACC_WIDTH,
    parameter int OUT_SHIFT = c_DEF_OUT_SHIFT,
    parameter int OUT_WIDTH = c_DEF_OUT_WIDTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        tx_enable,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_I,
    input  logic signed [IN_WIDTH-1:0]  in_Q,
    output logic                        out_strobe,
    output logic signed [OUT_WIDTH-1:0] out_I,
    output logic signed [OUT_WIDTH-1:0] out_Q,
    output logic                        underrun
`ifdef TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                 underrun_count
`endif
);

    localparam int c_PHASE_W = (clog2(INTERP) < 1) ? 1 : clog2(INTERP);

    logic                       w_flush;
    logic                       w_tick;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_underrun;
    logic [1:0]                 w_count_next;
    logic signed [IN_WIDTH-1:0] w_cic_i;
    logic signed [IN_WIDTH-1:0] w_cic_q;

    logic [c_PHASE_W-1:0]       r_phase;
    logic [1:0]                 r_count;
    logic                       r_wr_ptr;
    logic                       r_rd_ptr;
    logic signed [IN_WIDTH-1:0] r_fifo_i [2];
    logic signed [IN_WIDTH-1:0] r_fifo_q [2];
    logic                       r_in_ready;
    logic                       r_out_strobe;
    logic                       r_underrun;

    assign w_flush      = reset | ~tx_enable;
    assign w_tick       = (r_phase == c_PHASE_W'(INTERP - 1));
    assign w_push       = in_valid & r_in_ready;
    assign w_pop        = w_tick & (r_count != 2'd0);
    assign w_underrun   = w_tick & (r_count == 2'd0);
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
    // An underrun feeds zero into the combs rather than skipping the tick.
    assign w_cic_i      = w_pop ? r_fifo_i[r_rd_ptr] : '0;
    assign w_cic_q      = w_pop ? r_fifo_q[r_rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_phase      <= '0;
            r_count      <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_strobe <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_phase      <= w_tick ? '0 : r_phase + c_PHASE_W'(1);
            r_count      <= w_count_next;
            r_wr_ptr     <= r_wr_ptr ^ w_push;
            r_rd_ptr     <= r_rd_ptr ^ w_pop;
            r_in_ready   <= (w_count_next < 2'd2);
            r_out_strobe <= 1'b1;
            r_underrun   <= w_underrun;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !w_flush) begin
            r_fifo_i[r_wr_ptr] <= in_I;
            r_fifo_q[r_wr_ptr] <= in_Q;
        end
    end

`ifdef TX_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_count;

    // Survives tx_enable drops; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_underrun_count <= '0;
        end else if (tx_enable && w_underrun && (r_underrun_count != 16'hFFFF)) begin
            r_underrun_count <= r_underrun_count + 16'd1;
        end
    end

    assign underrun_count = r_underrun_count;
`endif

    tx_cic_interp #(
        .STAGES    (STAGES),
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_SHIFT (OUT_SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_cic_i (
        .clk      (clock),
        .rst      (w_flush),
        .i_tick   (w_tick),
        .i_sample (w_cic_i),
        .o_sample (out_I)
    );

    tx_cic_interp #(
        .STAGES    (STAGES),
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_SHIFT (OUT_SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_cic_q (
        .clk      (clock),
        .rst      (w_flush),
        .i_tick   (w_tick),
        .i_sample (w_cic_q),
        .o_sample (out_Q)
    );

    assign in_ready   = r_in_ready;
    assign out_strobe = r_out_strobe;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire
